// File: rtl/exec_hazard_ctrl.sv
// Issue/hazard controller for the 16-bit execution stage: in-flight write scoreboard,
// stall/forward decision and drain-and-halt FSM. Optional macro: FORWARD_EN (s2 forwarding).
module exec_hazard_ctrl #(
  parameter int unsigned LAT   = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [3:0]       id_rs,
  input  logic             id_rs_used,
  input  logic [3:0]       id_rt,
  input  logic             id_rt_used,
  input  logic             id_we,
  input  logic [3:0]       id_rdest,
  input  logic             halt_req,
  output logic             issue,
  output logic             stall,
  output logic             fwd_a,
  output logic             fwd_b,
  output logic             ex_we,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALTED
  } state_e;

  state_e state_q, state_d;

  logic [LAT-1:0] slot_v_q, slot_v_d;
  logic [3:0]     slot_rd_q [LAT];
  logic [3:0]     slot_rd_d [LAT];

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [LAT-1:0] hit_a, hit_b;
  logic           hazard;
  logic           slots_empty;

  // Source match against every in-flight slot
  always_comb begin
    hit_a = '0;
    hit_b = '0;
    for (int unsigned k = 0; k < LAT; k++) begin
      hit_a[k] = id_rs_used & slot_v_q[k] & (slot_rd_q[k] == id_rs);
      hit_b[k] = id_rt_used & slot_v_q[k] & (slot_rd_q[k] == id_rt);
    end
  end

`ifdef FORWARD_EN
  logic young_a, young_b;

  // Only slot[LAT-1] is on s2; any younger hit must stall and wins over forwarding
  always_comb begin
    young_a = 1'b0;
    young_b = 1'b0;
    for (int unsigned k = 0; k < LAT - 1; k++) begin
      young_a = young_a | hit_a[k];
      young_b = young_b | hit_b[k];
    end
    hazard = young_a | young_b;
    fwd_a  = hit_a[LAT-1] & ~young_a;
    fwd_b  = hit_b[LAT-1] & ~young_b;
  end
`else
  always_comb begin
    hazard = (|hit_a) | (|hit_b);
    fwd_a  = 1'b0;
    fwd_b  = 1'b0;
  end
`endif

  assign slots_empty = ~|slot_v_q;

  // Issue is also blocked on the cycle halt_req is first seen in RUN
  always_comb begin
    issue = id_valid & ~hazard & (state_q == ST_RUN) & ~halt_req;
    stall = id_valid & ~issue;
    ex_we = id_we & issue;
  end

  always_comb begin
    slot_v_d     = '0;
    slot_v_d[0]  = issue & id_we;
    slot_rd_d[0] = id_rdest;
    for (int unsigned k = 1; k < LAT; k++) begin
      slot_v_d[k]  = slot_v_q[k-1];
      slot_rd_d[k] = slot_rd_q[k-1];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN: begin
        if (halt_req) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!halt_req)        state_d = ST_RUN;
        else if (slots_empty) state_d = ST_HALTED;
      end
      ST_HALTED: begin
        if (!halt_req) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      slot_v_q    <= '0;
      stall_cnt_q <= '0;
      for (int unsigned k = 0; k < LAT; k++) slot_rd_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      slot_v_q    <= slot_v_d;
      stall_cnt_q <= stall_cnt_d;
      for (int unsigned k = 0; k < LAT; k++) slot_rd_q[k] <= slot_rd_d[k];
    end
  end

  assign halted    = (state_q == ST_HALTED);
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_exec_hazard_ctrl.sv
// Directed bench for exec_hazard_ctrl (LAT=2, narrow counter to reach saturation).
module tb_exec_hazard_ctrl;

  localparam int unsigned LAT   = 2;
  localparam int unsigned CNT_W = 4;
`ifdef FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             id_valid;
  logic [3:0]       id_rs;
  logic             id_rs_used;
  logic [3:0]       id_rt;
  logic             id_rt_used;
  logic             id_we;
  logic [3:0]       id_rdest;
  logic             halt_req;
  logic             issue;
  logic             stall;
  logic             fwd_a;
  logic             fwd_b;
  logic             ex_we;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;

  int unsigned n_tests;
  int unsigned n_fail;
  logic [CNT_W-1:0] cnt_exp;

  exec_hazard_ctrl #(.LAT(LAT), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rs_used (id_rs_used),
    .id_rt      (id_rt),
    .id_rt_used (id_rt_used),
    .id_we      (id_we),
    .id_rdest   (id_rdest),
    .halt_req   (halt_req),
    .issue      (issue),
    .stall      (stall),
    .fwd_a      (fwd_a),
    .fwd_b      (fwd_b),
    .ex_we      (ex_we),
    .halted     (halted),
    .stall_cnt  (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [3:0] rs, input logic rsu,
                     input logic [3:0] rt, input logic rtu, input logic we,
                     input logic [3:0] rd);
    id_valid   = v;
    id_rs      = rs;
    id_rs_used = rsu;
    id_rt      = rt;
    id_rt_used = rtu;
    id_we      = we;
    id_rdest   = rd;
  endtask

  task automatic idle();
    drv(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0);
  endtask

  // Samples the combinational outputs mid-cycle; a stalled cycle advances the count model
  task automatic expect_out(input string tag, input logic iss, input logic stl,
                            input logic fa, input logic fb, input logic we);
    @(negedge clk);
    chk({tag, ".issue"}, 32'(issue), 32'(iss));
    chk({tag, ".stall"}, 32'(stall), 32'(stl));
    chk({tag, ".fwd_a"}, 32'(fwd_a), 32'(fa));
    chk({tag, ".fwd_b"}, 32'(fwd_b), 32'(fb));
    chk({tag, ".ex_we"}, 32'(ex_we), 32'(we));
    if (stl && cnt_exp != '1) cnt_exp = cnt_exp + 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    idle();
    step();
    step();
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    cnt_exp  = '0;
    rst      = 1'b1;
    halt_req = 1'b0;
    idle();
    step();
    step();
    rst = 1'b0;

    // Reset state
    expect_out("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset.halted", 32'(halted), 32'd0);
    chk("reset.cnt", 32'(stall_cnt), 32'd0);
    step();

    // Independent stream
    drv(1'b1, 4'd2, 1'b1, 4'd3, 1'b1, 1'b1, 4'd1);
    expect_out("indep0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    drv(1'b1, 4'd5, 1'b1, 4'd6, 1'b1, 1'b1, 4'd4);
    expect_out("indep1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    flush();
    chk("indep.cnt", 32'(stall_cnt), 32'd0);

    // Back-to-back RAW on operand A
    drv(1'b1, 4'd2, 1'b1, 4'd3, 1'b1, 1'b1, 4'd1);
    expect_out("b2b.wr", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    drv(1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 1'b1, 4'd8);
    expect_out("b2b.st1", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    if (FWD) begin
      expect_out("b2b.fwd", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    end else begin
      expect_out("b2b.st2", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      expect_out("b2b.iss", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    step();
    chk("b2b.cnt", 32'(stall_cnt), FWD ? 32'd1 : 32'd2);
    flush();

    // Distance-2 RAW on operand B
    drv(1'b1, 4'd2, 1'b1, 4'd3, 1'b1, 1'b1, 4'd7);
    expect_out("d2.wr", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    drv(1'b1, 4'd4, 1'b1, 4'd5, 1'b1, 1'b1, 4'd9);
    expect_out("d2.mid", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    drv(1'b1, 4'd10, 1'b1, 4'd7, 1'b1, 1'b1, 4'd11);
    if (FWD) begin
      expect_out("d2.fwd", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    end else begin
      expect_out("d2.st", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      expect_out("d2.iss", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    step();
    flush();
    chk("d2.cnt", 32'(stall_cnt), 32'(cnt_exp));

    // Unused source matching an in-flight write
    drv(1'b1, 4'd2, 1'b1, 4'd3, 1'b1, 1'b1, 4'd1);
    expect_out("unused.wr", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    drv(1'b1, 4'd1, 1'b0, 4'd12, 1'b1, 1'b0, 4'd13);
    expect_out("unused.rd", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    flush();

    // Two writes to r1 in flight: the younger one governs
    drv(1'b1, 4'd2, 1'b1, 4'd3, 1'b1, 1'b1, 4'd1);
    expect_out("yng.wr0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    drv(1'b1, 4'd4, 1'b1, 4'd5, 1'b1, 1'b1, 4'd1);
    expect_out("yng.wr1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    drv(1'b1, 4'd1, 1'b1, 4'd6, 1'b1, 1'b1, 4'd14);
    expect_out("yng.st", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    if (FWD) begin
      expect_out("yng.fwd", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    end else begin
      expect_out("yng.st2", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
      expect_out("yng.iss", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    step();
    flush();
    chk("yng.cnt", 32'(stall_cnt), 32'(cnt_exp));

    // Drain and halt with two writes in flight, then hold to saturate the counter
    drv(1'b1, 4'd2, 1'b1, 4'd3, 1'b1, 1'b1, 4'd1);
    expect_out("halt.wr1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    drv(1'b1, 4'd4, 1'b1, 4'd5, 1'b1, 1'b1, 4'd2);
    expect_out("halt.wr2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    halt_req = 1'b1;
    drv(1'b1, 4'd5, 1'b1, 4'd6, 1'b1, 1'b1, 4'd3);
    expect_out("halt.req", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("halt.h0", 32'(halted), 32'd0);
    step();
    expect_out("halt.dr1", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("halt.h1", 32'(halted), 32'd0);
    step();
    expect_out("halt.dr2", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("halt.h2", 32'(halted), 32'd0);
    step();
    expect_out("halt.hlt", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("halt.h3", 32'(halted), 32'd1);
    chk("halt.cnt", 32'(stall_cnt), 32'(cnt_exp - 1'b1));
    step();
    for (int i = 0; i < 16; i++) begin
      expect_out("sat.hold", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
    end
    chk("sat.cnt", 32'(stall_cnt), 32'hF);
    chk("sat.model", 32'(stall_cnt), 32'(cnt_exp));
    chk("sat.halted", 32'(halted), 32'd1);
    halt_req = 1'b0;
    expect_out("halt.drop", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("halt.drop.h", 32'(halted), 32'd1);
    step();
    expect_out("halt.resume", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("halt.resume.h", 32'(halted), 32'd0);
    step();
    flush();
    chk("sat.stay", 32'(stall_cnt), 32'hF);

    // Reset while a RAW stall is pending
    drv(1'b1, 4'd2, 1'b1, 4'd3, 1'b1, 1'b1, 4'd1);
    expect_out("rst.wr", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    drv(1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 1'b1, 4'd8);
    expect_out("rst.st", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    cnt_exp = '0;
    expect_out("rst.iss", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst.cnt", 32'(stall_cnt), 32'd0);
    chk("rst.halted", 32'(halted), 32'd0);
    step();
    flush();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/exec_hazard_ctrl.md
Name: exec_hazard_ctrl

Overview:
Issue/hazard controller for the 16-bit execution stage. It sits between decode and the execution stage and tracks in-flight register writes in a small scoreboard. It decides each cycle whether the decoded instruction issues, stalls or gets operands forwarded. It also provides a drain-and-halt sequence for debug and reset-free pipeline quiescing.

Parameters:
LAT, 2, cycles from issue until the write is visible in the register file (in-flight slots tracked; legal 1..4)
CNT_W, 16, width of the saturating stall counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
id_valid  in  1  decode holds a valid instruction
id_rs  in  4  source A register (feeds rd_data path)
id_rs_used  in  1  source A is read
id_rt  in  4  source B register (feeds s0 path)
id_rt_used  in  1  source B is read
id_we  in  1  instruction writes a register
id_rdest  in  4  destination register
halt_req  in  1  level request to drain and halt
issue  out  1  instruction accepted into execution this cycle
stall  out  1  hold decode/fetch registers
fwd_a  out  1  select execution result s2 for operand A instead of register-file data
fwd_b  out  1  same for operand B
ex_we  out  1  gated write enable to execution stage (id_we & issue)
halted  out  1  pipeline empty and halted
stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Interface: one clock clk; rst is synchronous, active-high. All state updates on the rising edge of clk.
- Reset: all slots invalid, FSM=RUN. issue=0, stall=0, fwd_a=0, fwd_b=0, ex_we=0, halted=0, stall_cnt=0.
- Scoreboard: shift register slot[0..LAT-1], each entry {v, rd}. Every cycle, slot[0] <= {issue & id_we, id_rdest}. slot[k] <= slot[k-1]. The oldest entry drops out.
- slot[LAT-1] is the instruction whose result appears on s2 this cycle.
- Match: src_hit_k = src_used & slot[k].v & (slot[k].rd == src). Register 0 is an ordinary register (no special-casing).
- Hazard, FORWARD_EN defined: stall if any src hits slot[0..LAT-2]. A hit only in slot[LAT-1] raises fwd_a/fwd_b with no stall. If a younger and an older slot both hit, the younger slot governs (stall).
- Hazard, FORWARD_EN undefined: stall on a hit in any slot. fwd_a and fwd_b are constant 0.
- issue = id_valid & ~hazard & (state==RUN). stall = id_valid & ~issue.
- Outputs issue, stall, fwd_a, fwd_b and ex_we are combinational from the current inputs and scoreboard. halted and stall_cnt are registered.
- A stalled cycle inserts a bubble: slot[0] gets v=0.
- FSM, RUN: if halt_req, go to DRAIN (no issue on that cycle).
- FSM, DRAIN: issue=0. When all slots are invalid, go to HALTED.
- FSM, HALTED: halted=1. When halt_req drops, return to RUN with halted=0 on the following cycle.
- halt_req deasserted while in DRAIN: return to RUN next cycle.
- stall_cnt increments on every cycle with stall=1, saturates at all-ones, and is cleared only by rst.
- In DRAIN/HALTED with id_valid=1, stall=1 and the cycle is counted.
- rst mid-operation: every in-flight slot is discarded immediately and the FSM returns to RUN.

Optional Feature:
FORWARD_EN
- Defined: forwarding from s2 on a slot[LAT-1] hit, as described above. This removes one stall per dependent back-to-back pair when LAT=2.
- Undefined: a pure interlock. fwd_a and fwd_b are tied 0, and every RAW hazard stalls until its write has left the scoreboard.

Test Plan:
- Independent stream: r1=r2+r3, then r4=r5+r6 on consecutive cycles -> issue=1 both cycles, stall=0, fwd_a=fwd_b=0, stall_cnt stays 0.
- Back-to-back dependency, LAT=2: write r1, next instruction reads rs=r1. With FORWARD_EN: one stall cycle, then issue with fwd_a=1; stall_cnt=1. Without FORWARD_EN: two stall cycles, then issue with fwd_a=0; stall_cnt=2.
- Distance-2 dependency, rt=r7 read two instructions after the write of r7 -> FORWARD_EN: no stall, fwd_b=1. Without: one stall.
- Unused source: id_rs=r1 with id_rs_used=0 while r1 is in flight -> no stall, fwd_a=0.
- Halt: assert halt_req with two writes in flight -> no issue. halted=1 once the scoreboard is empty; deassert -> halted=0 next cycle, and issue resumes.
- Reset during stall: rst asserted while stall=1 -> next cycle all slots are invalid, stall_cnt=0, and the pending instruction issues without stall.
